ram_arbiter_2to1: RTL and testbench
===================================

# ram_arbiter_2to1

Two-host to single-port RAM arbiter between the core's instruction and data OBI-style ports and a 1-cycle-latency single-port RAM. It replaces ad-hoc glue logic:
- grants one host per cycle using round-robin;
- tracks which host owns the in-flight RAM access and steers the read response back to it;
- answers accesses outside the RAM window with a local error response;
- keeps saturating grant and error counters for bench monitors.

## Interface
Parameters:
- MemStart, 32'h0000_0000, base address of the RAM window.
- MemSize, 65536, window size in bytes; must be a power of two.
- CntWidth, 32, width of each statistics counter.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  instruction host request.
- instr_addr_i  in  32  instruction byte address.
- instr_gnt_o  out  1  instruction request accepted this cycle.
- instr_rvalid_o  out  1  instruction response valid.
- instr_rdata_o  out  32  instruction read data.
- instr_err_o  out  1  instruction response error.
- data_req_i  in  1  data host request.
- data_we_i  in  1  data write enable.
- data_be_i  in  4  data byte enables.
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  data write data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data response valid; also asserted for writes.
- data_rdata_o  out  32  data read data.
- data_err_o  out  1  data response error.
- mem_req_o  out  1  RAM request.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  4  RAM byte enables.
- mem_addr_o  out  32  RAM byte address.
- mem_wdata_o  out  32  RAM write data.
- mem_rvalid_i  in  1  RAM response, exactly one cycle after mem_req_o.
- mem_rdata_i  in  32  RAM read data.
- instr_cnt_o  out  CntWidth  instruction grants, saturating.
- data_cnt_o  out  CntWidth  data grants, saturating.
- err_cnt_o  out  CntWidth  error responses issued, saturating.

## Operation
- In range means `(addr & ~(MemSize-1)) == MemStart`.
- Arbitration is combinational within the cycle:
  - Only one host requesting: that host wins.
  - Both requesting: the host that did not win the last grant wins.
  - The last-winner register resets to "data", so instruction wins the first contention.
- The winner's gnt is asserted in the same cycle as its req. The loser's gnt stays 0, and the loser must hold its req and signals.
- Winner in range: drive mem_req_o=1 and forward addr/we/be/wdata. For instruction grants, force mem_we_o=0 and mem_be_o=4'hF.
- Winner out of range: mem_req_o stays 0, and a local error response is scheduled.
- With no grant, all mem_* outputs are 0.
- Response state is registered every cycle:
  - resp_valid: a grant occurred.
  - resp_owner: 0 = instr, 1 = data.
  - resp_err: the granted access was out of range.
- Response cycle (the cycle after the grant), owner port only:
  - rvalid_o=1.
  - err_o=resp_err.
  - rdata_o = mem_rdata_i when not an error, otherwise 32'h0.
- The non-owner port's rvalid, err and rdata are all 0.
- resp_valid with resp_err=0 but mem_rvalid_i=0 is a RAM protocol violation. In that case the arbiter still asserts rvalid and passes rdata through; the bench flags it with an assertion.
- Counters increment on the corresponding grant or error-response cycle and saturate at all-ones, with no wrap.

## Timing
- Reset values: all outputs 0; resp_valid=0; last winner = data; all counters 0.
- Reset asserted mid-access drops the pending response; no rvalid is issued after reset releases.
- gnt to rvalid latency is exactly 1 cycle for both RAM and error responses.
- Throughput is one grant per cycle. Back-to-back grants produce back-to-back responses, and responses never collide because only one grant is made per cycle.
- Sustained contention alternates I, D, I, D…; neither host waits more than 1 cycle.
- A grant in the same cycle as a response is allowed and pipelines normally.
- err_cnt_o increments in the response cycle, not the grant cycle.

## Test plan
- **Single instruction read.** Preload RAM[0x80]=32'h0000_0013. instr req addr 0x80 → instr_gnt_o same cycle; next cycle instr_rvalid_o=1, rdata=32'h0000_0013, err=0; instr_cnt_o=1.
- **Simultaneous requests.** instr 0x100 and data read 0x200 both requested for 4 cycles with req held until granted → grants I, D, I, D; each rvalid lands on the correct port one cycle after its grant with the matching data.
- **Data write.** data we=1, be=4'b0011, addr 0x40, wdata 32'hAABB_CCDD → RAM sees those exact signals; data_rvalid_o=1 next cycle with err=0. A later read of 0x40 returns the low halfword 16'hCCDD merged with the prior upper bytes.
- **Out-of-range access.** data read of 0x0001_0000 with MemSize=64K → mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, rdata=0; err_cnt_o=1.
- **Reset mid-access.** Assert rst_i in the cycle after a grant → all outputs 0 immediately; after release there is no stray rvalid, and all counters are 0.
- **Counter saturation.** With CntWidth=4, issue 20 instruction grants → instr_cnt_o holds 4'hF.

Source files
------------

// File: rtl/ram_arbiter_2to1.sv
// Round-robin arbiter sharing one 1-cycle-latency single-port RAM between the
// instruction and data OBI ports, with local error responses and saturating counters.
module ram_arbiter_2to1 #(
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int unsigned MemSize  = 65536,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [31:0]         data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [CntWidth-1:0] instr_cnt_o,
  output logic [CntWidth-1:0] data_cnt_o,
  output logic [CntWidth-1:0] err_cnt_o
);

  localparam logic [31:0]         WinMask = ~(32'(MemSize) - 32'd1);
  localparam logic [CntWidth-1:0] CntMax  = '1;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } owner_e;

  owner_e              last_winner_q;
  owner_e              resp_owner_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic                grant_instr;
  logic                grant_data;
  logic                instr_in_range;
  logic                data_in_range;
  logic                win_in_range;
  logic                resp_to_instr;
  logic                resp_to_data;
  logic [31:0]         resp_rdata;
  logic [CntWidth-1:0] instr_cnt_q;
  logic [CntWidth-1:0] data_cnt_q;
  logic [CntWidth-1:0] err_cnt_q;
  logic                unused_mem_rvalid;

  // RAM rvalid is only monitored externally; read data is passed through regardless.
  assign unused_mem_rvalid = mem_rvalid_i;

  // Grants are gated by reset so every output is quiet while rst_i is high.
  always_comb begin
    instr_in_range = (instr_addr_i & WinMask) == MemStart;
    data_in_range  = (data_addr_i & WinMask) == MemStart;
    grant_instr    = !rst_i && instr_req_i && (!data_req_i || last_winner_q == OwnerData);
    grant_data     = !rst_i && data_req_i && (!instr_req_i || last_winner_q == OwnerInstr);
    win_in_range   = grant_instr ? instr_in_range : data_in_range;
    instr_gnt_o    = grant_instr;
    data_gnt_o     = grant_data;
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (grant_instr && instr_in_range) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i;
    end else if (grant_data && data_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_winner_q <= OwnerData;
      resp_valid_q  <= 1'b0;
      resp_owner_q  <= OwnerInstr;
      resp_err_q    <= 1'b0;
    end else begin
      resp_valid_q <= grant_instr || grant_data;
      resp_owner_q <= grant_data ? OwnerData : OwnerInstr;
      resp_err_q   <= (grant_instr || grant_data) && !win_in_range;
      if (grant_instr || grant_data) begin
        last_winner_q <= grant_data ? OwnerData : OwnerInstr;
      end
    end
  end

  always_comb begin
    resp_to_instr  = resp_valid_q && resp_owner_q == OwnerInstr;
    resp_to_data   = resp_valid_q && resp_owner_q == OwnerData;
    resp_rdata     = resp_err_q ? 32'h0 : mem_rdata_i;
    instr_rvalid_o = resp_to_instr;
    instr_err_o    = resp_to_instr && resp_err_q;
    instr_rdata_o  = resp_to_instr ? resp_rdata : 32'h0;
    data_rvalid_o  = resp_to_data;
    data_err_o     = resp_to_data && resp_err_q;
    data_rdata_o   = resp_to_data ? resp_rdata : 32'h0;
  end

  // Error responses are counted when they are delivered, not when granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_cnt_q <= '0;
      data_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (grant_instr && instr_cnt_q != CntMax) begin
        instr_cnt_q <= instr_cnt_q + CntOne;
      end
      if (grant_data && data_cnt_q != CntMax) begin
        data_cnt_q <= data_cnt_q + CntOne;
      end
      if (resp_valid_q && resp_err_q && err_cnt_q != CntMax) begin
        err_cnt_q <= err_cnt_q + CntOne;
      end
    end
  end

  assign instr_cnt_o = instr_cnt_q;
  assign data_cnt_o  = data_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_ram_arbiter_2to1.sv
// Bench for ram_arbiter_2to1: behavioural 1-cycle RAM, response scoreboard and
// per-feature tasks for grants, steering, errors, reset and counter saturation.
module tb_ram_arbiter_2to1;

  localparam int CW = 4;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [31:0]   instr_rdata_o;
  logic          instr_err_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [31:0]   data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          data_err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic [CW-1:0] instr_cnt_o;
  logic [CW-1:0] data_cnt_o;
  logic [CW-1:0] err_cnt_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_has;
  logic [31:0] ram [0:16383];

  ram_arbiter_2to1 #(.MemStart(32'h0), .MemSize(65536), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_cnt_o(instr_cnt_o), .data_cnt_o(data_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM; idle read data is junk so the arbiter's zeroing is visible.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rvalid_i  <= 1'b0;
      mem_rdata_i   <= 32'hDEAD_BEEF;
      ram[14'h0020] <= 32'h0000_0013;
      ram[14'h0040] <= 32'h1111_0100;
      ram[14'h0080] <= 32'h2222_0200;
      ram[14'h0010] <= 32'h5566_7788;
      ram[14'h3FFF] <= 32'hCAFE_F00D;
    end else if (mem_req_o) begin
      mem_rvalid_i <= 1'b1;
      mem_rdata_i  <= ram[mem_addr_o[15:2]];
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) ram[mem_addr_o[15:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end
    end else begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: every out-of-reset cycle, the response ports must match the entry due now.
  always @(negedge clk) begin
    if (!rst) begin
      mon_has = 1'b0;
      mon_e   = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e   = exp_q.pop_front();
        mon_has = 1'b1;
      end
      vectors++;
      if ({instr_rvalid_o, data_rvalid_o} !== {mon_has && !mon_e.owner, mon_has && mon_e.owner}) begin
        miscompares++;
        $display("[TB] FAIL rvalid cyc %0d: got i/d %b%b, want %b%b", cyc, instr_rvalid_o, data_rvalid_o,
                 mon_has && !mon_e.owner, mon_has && mon_e.owner);
      end
      vectors++;
      if ({instr_err_o, data_err_o} !== {mon_has && !mon_e.owner && mon_e.err, mon_has && mon_e.owner && mon_e.err}) begin
        miscompares++;
        $display("[TB] FAIL err cyc %0d: got i/d %b%b, want %b%b", cyc, instr_err_o, data_err_o,
                 mon_has && !mon_e.owner && mon_e.err, mon_has && mon_e.owner && mon_e.err);
      end
      if (!(mon_has && !mon_e.owner && !mon_e.chk_data)) begin
        vectors++;
        if (instr_rdata_o !== ((mon_has && !mon_e.owner) ? mon_e.data : 32'h0)) begin
          miscompares++;
          $display("[TB] FAIL instr_rdata cyc %0d: got %h, want %h", cyc, instr_rdata_o,
                   (mon_has && !mon_e.owner) ? mon_e.data : 32'h0);
        end
      end
      if (!(mon_has && mon_e.owner && !mon_e.chk_data)) begin
        vectors++;
        if (data_rdata_o !== ((mon_has && mon_e.owner) ? mon_e.data : 32'h0)) begin
          miscompares++;
          $display("[TB] FAIL data_rdata cyc %0d: got %h, want %h", cyc, data_rdata_o,
                   (mon_has && mon_e.owner) ? mon_e.data : 32'h0);
        end
      end
      if ((instr_rvalid_o && !instr_err_o) || (data_rvalid_o && !data_err_o)) begin
        assert (mem_rvalid_i) else $error("[TB] RAM response missing in cyc %0d", cyc);
      end
    end
  end

  task automatic clear_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
  endtask

  task automatic push_exp(input logic owner, input logic err, input logic chk, input logic [31:0] d);
    exp_t e;
    e.owner = owner; e.err = err; e.chk_data = chk; e.data = d; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h80;
    data_req_i  = 1'b1; data_addr_i  = 32'h200; data_be_i = 4'hF;
    @(negedge clk);
    vectors++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
         instr_rvalid_o, instr_err_o, instr_rdata_o, data_rvalid_o, data_err_o, data_rdata_o,
         instr_cnt_o, data_cnt_o, err_cnt_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got gnt %b%b mem_req %b addr %h cnt %h/%h/%h, want all 0",
               instr_gnt_o, data_gnt_o, mem_req_o, mem_addr_o, instr_cnt_o, data_cnt_o, err_cnt_o);
    end
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, instr_cnt_o, data_cnt_o, err_cnt_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got gnt %b%b mem_req %b cnt %h/%h/%h, want all 0",
               instr_gnt_o, data_gnt_o, mem_req_o, instr_cnt_o, data_cnt_o, err_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_instr();
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h80;
    @(negedge clk);
    vectors++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL single_gnt: got i/d %b%b, want 10", instr_gnt_o, data_gnt_o);
    end
    vectors++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h80}) begin
      miscompares++;
      $display("[TB] FAIL single_mem: got req %b we %b be %h addr %h, want 1 0 f 00000080",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    push_exp(1'b0, 1'b0, 1'b1, 32'h0000_0013);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    vectors++;
    if ({instr_cnt_o, data_cnt_o} !== {4'd1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL single_cnt: got %h/%h, want 1/0", instr_cnt_o, data_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    data_req_i  = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_gnt_o, data_gnt_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("[TB] FAIL rr_gnt k=%0d: got i/d %b%b, want %b", k, instr_gnt_o, data_gnt_o,
                 (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      vectors++;
      if (mem_addr_o !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin
        miscompares++;
        $display("[TB] FAIL rr_addr k=%0d: got %h, want %h", k, mem_addr_o,
                 (k % 2 == 0) ? 32'h100 : 32'h200);
      end
      if (k % 2 == 0) push_exp(1'b0, 1'b0, 1'b1, 32'h1111_0100);
      else            push_exp(1'b1, 1'b0, 1'b1, 32'h2222_0200);
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    vectors++;
    if ({instr_cnt_o, data_cnt_o} !== {4'd2, 4'd2}) begin
      miscompares++;
      $display("[TB] FAIL rr_cnt: got %h/%h, want 2/2", instr_cnt_o, data_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_data_write();
    logic [31:0] prior;
    logic [31:0] wd;
    prior = 32'h5566_7788;
    wd    = 32'hAABB_CCDD;
    do_reset();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011; data_addr_i = 32'h40; data_wdata_i = wd;
    @(negedge clk);
    vectors++;
    if ({data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
        {1'b1, 1'b1, 1'b1, 4'b0011, 32'h40, wd}) begin
      miscompares++;
      $display("[TB] FAIL write_mem: got gnt %b req %b we %b be %b addr %h wdata %h, want 1 1 1 0011 00000040 %h",
               data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, wd);
    end
    push_exp(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
    @(negedge clk);
    vectors++;
    if ({data_gnt_o, mem_req_o, mem_we_o} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL readback_mem: got gnt %b req %b we %b, want 1 1 0", data_gnt_o, mem_req_o, mem_we_o);
    end
    push_exp(1'b1, 1'b0, 1'b1, {prior[31:16], wd[15:0]});
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (data_cnt_o !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL write_cnt: got %h, want 2", data_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    do_reset();
    data_req_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h0001_0000;
    @(negedge clk);
    vectors++;
    if ({data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 70'h0}) begin
      miscompares++;
      $display("[TB] FAIL oor_data_mem: got gnt %b req %b addr %h, want 1 0 00000000", data_gnt_o, mem_req_o, mem_addr_o);
    end
    push_exp(1'b1, 1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    clear_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h0002_0000;
    @(negedge clk);
    vectors++;
    if ({instr_gnt_o, mem_req_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL oor_instr_mem: got gnt %b req %b, want 1 0", instr_gnt_o, mem_req_o);
    end
    push_exp(1'b0, 1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    clear_inputs();
    data_req_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h0000_FFFC;
    @(negedge clk);
    vectors++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_FFFC}) begin
      miscompares++;
      $display("[TB] FAIL top_of_window: got req %b addr %h, want 1 0000fffc", mem_req_o, mem_addr_o);
    end
    vectors++;
    if (err_cnt_o !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL err_cnt_1: got %h, want 1", err_cnt_o);
    end
    push_exp(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    vectors++;
    if ({err_cnt_o, instr_cnt_o, data_cnt_o} !== {4'd2, 4'd1, 4'd2}) begin
      miscompares++;
      $display("[TB] FAIL oor_cnt: got err/i/d %h/%h/%h, want 2/1/2", err_cnt_o, instr_cnt_o, data_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h80;
    @(negedge clk);
    vectors++;
    if (instr_gnt_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_gnt: got %b, want 1", instr_gnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, instr_rvalid_o, instr_rdata_o, data_rvalid_o,
         instr_cnt_o, data_cnt_o, err_cnt_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got rvalid %b rdata %h cnt %h, want all 0",
               instr_rvalid_o, instr_rdata_o, instr_cnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_rvalid_o, data_rvalid_o, instr_cnt_o, data_cnt_o, err_cnt_o} !== '0) begin
        miscompares++;
        $display("[TB] FAIL post_reset k=%0d: got rvalid %b%b cnt %h/%h/%h, want all 0", k,
                 instr_rvalid_o, data_rvalid_o, instr_cnt_o, data_cnt_o, err_cnt_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h80;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_gnt_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sat_gnt k=%0d: got %b, want 1", k, instr_gnt_o);
      end
      if (k == 15) begin
        vectors++;
        if (instr_cnt_o !== 4'hF) begin
          miscompares++;
          $display("[TB] FAIL sat_reach: got %h, want f", instr_cnt_o);
        end
      end
      push_exp(1'b0, 1'b0, 1'b1, 32'h0000_0013);
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    vectors++;
    if ({instr_cnt_o, data_cnt_o} !== {4'hF, 4'h0}) begin
      miscompares++;
      $display("[TB] FAIL sat_hold: got %h/%h, want f/0", instr_cnt_o, data_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_instr();
    test_back_to_back();
    test_data_write();
    test_out_of_range();
    test_reset_mid_access();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
